// File: rtl/nvm_pkg.sv
// Shared NVM flush-path types: block/page/flash address widths, GC sequencer
// states, flash command encodings and the flash addressing helper.
package nvm_pkg;

  localparam int BLOCK_W      = 10;
  localparam int PAGE_W       = 6;
  localparam int FLASH_ADDR_W = 28;
  localparam int GC_THRESHOLD = 16;

  typedef logic [BLOCK_W-1:0]      block_t;
  typedef logic [PAGE_W-1:0]       page_t;
  typedef logic [FLASH_ADDR_W-1:0] flash_addr_t;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_INTERRUPT  = 4'd1,
    S_INI        = 4'd2,
    S_INI_DONE   = 4'd3,
    S_MOVE_START = 4'd4,
    S_FINISH     = 4'd5,
    S_MOVE_CHK   = 4'd6,
    S_MOVE_WAIT  = 4'd7,
    S_ERASE      = 4'd8
  } gc_state_t;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_COPY  = 2'b01,
    CMD_ERASE = 2'b10
  } fl_cmd_t;

  // Flash address layout: {zero pad, block, page}
  function automatic flash_addr_t mk_flash_addr(block_t blk, page_t page);
    return flash_addr_t'({blk, page});
  endfunction

endpackage

// File: rtl/gc_controller.sv
// Garbage-collection sequencer: fetches a victim/destination block pair, copies
// every valid victim page with copy-back + map update, then erases the victim.
module gc_controller
  import nvm_pkg::*;
(
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      gc_en,
  input  logic                      gc_force,
  input  logic [BLOCK_W:0]          free_blk_cnt,
  input  logic                      host_req,
  output logic                      blk_req,
  input  logic                      blk_ack,
  input  logic [BLOCK_W-1:0]        victim_blk,
  input  logic [BLOCK_W-1:0]        dest_blk,
  output logic [BLOCK_W+PAGE_W-1:0] pv_addr,
  input  logic                      pv_data,
  output logic                      fl_req,
  output logic [1:0]                fl_cmd,
  output logic [FLASH_ADDR_W-1:0]   fl_src,
  output logic [FLASH_ADDR_W-1:0]   fl_dst,
  input  logic                      fl_ack,
  output logic                      map_upd,
  output logic                      gc_busy,
  output logic                      gc_done,
  output logic [3:0]                state
);

  localparam logic [BLOCK_W:0] TH_CNT = (BLOCK_W+1)'(GC_THRESHOLD);

  gc_state_t   cur_st, nxt_st;
  page_t       page_idx, page_nxt;
  block_t      victim, victim_nxt;
  block_t      dest, dest_nxt;
  logic        fl_req_q, fl_req_nxt;
  fl_cmd_t     fl_cmd_q, fl_cmd_nxt;
  flash_addr_t fl_src_q, fl_src_nxt;
  flash_addr_t fl_dst_q, fl_dst_nxt;
  logic        map_upd_q, map_upd_nxt;
  logic        force_pend, force_nxt;
  logic        erase_issued, erase_iss_nxt;
  logic        resume_erase, resume_nxt;
  logic        trig;
  logic        adv;

  assign trig = gc_force | force_pend | (gc_en & (free_blk_cnt < TH_CNT));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cur_st       <= S_IDLE;
      page_idx     <= '0;
      victim       <= '0;
      dest         <= '0;
      fl_req_q     <= 1'b0;
      fl_cmd_q     <= CMD_NOP;
      fl_src_q     <= '0;
      fl_dst_q     <= '0;
      map_upd_q    <= 1'b0;
      force_pend   <= 1'b0;
      erase_issued <= 1'b0;
      resume_erase <= 1'b0;
    end else begin
      cur_st       <= nxt_st;
      page_idx     <= page_nxt;
      victim       <= victim_nxt;
      dest         <= dest_nxt;
      fl_req_q     <= fl_req_nxt;
      fl_cmd_q     <= fl_cmd_nxt;
      fl_src_q     <= fl_src_nxt;
      fl_dst_q     <= fl_dst_nxt;
      map_upd_q    <= map_upd_nxt;
      force_pend   <= force_nxt;
      erase_issued <= erase_iss_nxt;
      resume_erase <= resume_nxt;
    end
  end

  always_comb begin
    nxt_st        = cur_st;
    page_nxt      = page_idx;
    victim_nxt    = victim;
    dest_nxt      = dest;
    fl_req_nxt    = fl_req_q;
    fl_cmd_nxt    = fl_cmd_q;
    fl_src_nxt    = fl_src_q;
    fl_dst_nxt    = fl_dst_q;
    map_upd_nxt   = 1'b0;
    force_nxt     = force_pend;
    erase_iss_nxt = erase_issued;
    resume_nxt    = resume_erase;
    adv           = 1'b0;

    case (cur_st)
      S_IDLE: begin
        if (trig && !host_req) begin
          nxt_st    = S_INI;
          force_nxt = 1'b0;
        end else if (gc_force) begin
          force_nxt = 1'b1;
        end
      end
      S_INI: begin
        if (blk_ack) begin
          victim_nxt = victim_blk;
          dest_nxt   = dest_blk;
          page_nxt   = '0;
          nxt_st     = S_INI_DONE;
        end
      end
      S_INI_DONE: nxt_st = S_MOVE_START;
      S_MOVE_START: begin
        if (host_req) begin
          nxt_st     = S_INTERRUPT;
          resume_nxt = 1'b0;
        end else begin
          nxt_st = S_MOVE_CHK;
        end
      end
      S_MOVE_CHK: begin
        if (pv_data) begin
          fl_req_nxt = 1'b1;
          fl_cmd_nxt = CMD_COPY;
          fl_src_nxt = mk_flash_addr(victim, page_idx);
          fl_dst_nxt = mk_flash_addr(dest, page_idx);
          nxt_st     = S_MOVE_WAIT;
        end else begin
          adv = 1'b1;
        end
      end
      S_MOVE_WAIT: begin
        // src/dst stay put so the map update names the page just copied
        if (fl_ack) begin
          fl_req_nxt  = 1'b0;
          fl_cmd_nxt  = CMD_NOP;
          map_upd_nxt = 1'b1;
          adv         = 1'b1;
        end
      end
      S_ERASE: begin
        if (!erase_issued) begin
          if (host_req) begin
            nxt_st     = S_INTERRUPT;
            resume_nxt = 1'b1;
          end else begin
            fl_req_nxt    = 1'b1;
            fl_cmd_nxt    = CMD_ERASE;
            fl_src_nxt    = mk_flash_addr(victim, '0);
            fl_dst_nxt    = '0;
            erase_iss_nxt = 1'b1;
          end
        end else if (fl_ack) begin
          fl_req_nxt    = 1'b0;
          fl_cmd_nxt    = CMD_NOP;
          erase_iss_nxt = 1'b0;
          nxt_st        = S_FINISH;
        end
      end
      S_INTERRUPT: begin
        if (!host_req) begin
          nxt_st     = resume_erase ? S_ERASE : S_MOVE_START;
          resume_nxt = 1'b0;
        end
      end
      S_FINISH: nxt_st = S_IDLE;
      default:  nxt_st = S_IDLE;
    endcase

    // The last page always ends in ERASE; page_idx never wraps
    if (adv) begin
      if (&page_idx) begin
        nxt_st        = S_ERASE;
        erase_iss_nxt = 1'b0;
      end else begin
        page_nxt = page_idx + page_t'(1);
        nxt_st   = S_MOVE_START;
      end
    end
  end

  assign blk_req = (cur_st == S_INI);
  assign pv_addr = (cur_st == S_MOVE_START) ? {victim, page_idx} : '0;
  assign fl_req  = fl_req_q;
  assign fl_cmd  = fl_cmd_q;
  assign fl_src  = fl_src_q;
  assign fl_dst  = fl_dst_q;
  assign map_upd = map_upd_q;
  assign gc_busy = (cur_st != S_IDLE);
  assign gc_done = (cur_st == S_FINISH);
  assign state   = cur_st;

endmodule

// File: tb/tb_gc_controller.sv
// Directed bench for gc_controller with block-manager, page-valid and flash
// responders, a command/map-update log, and a per-run expected-command model.
module tb_gc_controller;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        gc_en, gc_force, host_req;
  logic [10:0] free_blk_cnt;
  logic        blk_req, blk_ack = 1'b0;
  logic [9:0]  victim_blk, dest_blk;
  logic [15:0] pv_addr;
  logic        pv_data = 1'b0;
  logic        fl_req;
  logic [1:0]  fl_cmd;
  logic [27:0] fl_src, fl_dst;
  logic        fl_ack = 1'b0;
  logic        map_upd, gc_busy, gc_done;
  logic [3:0]  state;

  logic [9:0]  cur_vic = 10'd0, cur_dst = 10'd0;
  logic [63:0] cur_mask = 64'd0;
  int          ack_cnt = 0;
  int          checks = 0, failures = 0;

  logic [1:0]  cmd_q[$];
  logic [27:0] src_q[$], dst_q[$], msrc_q[$], mdst_q[$];
  int          done_cnt = 0;
  logic        fl_req_prev = 1'b0;

  typedef struct {
    logic        en;
    logic        frc;
    logic [10:0] cnt;
    logic [9:0]  vic;
    logic [9:0]  dst;
    logic [63:0] mask;
    int          exp_copies;
    logic [27:0] exp_erase;
  } vec_t;

  vec_t vecs[4];

  always #5 CLK = ~CLK;

  gc_controller dut (
    .CLK(CLK), .nRST(nRST), .gc_en(gc_en), .gc_force(gc_force),
    .free_blk_cnt(free_blk_cnt), .host_req(host_req),
    .blk_req(blk_req), .blk_ack(blk_ack), .victim_blk(victim_blk), .dest_blk(dest_blk),
    .pv_addr(pv_addr), .pv_data(pv_data),
    .fl_req(fl_req), .fl_cmd(fl_cmd), .fl_src(fl_src), .fl_dst(fl_dst), .fl_ack(fl_ack),
    .map_upd(map_upd), .gc_busy(gc_busy), .gc_done(gc_done), .state(state)
  );

  assign victim_blk = cur_vic;
  assign dest_blk   = cur_dst;

  // Responders: block manager, page-valid table (1-cycle latency), flash (ack 3 cycles after req)
  always @(posedge CLK) begin
    blk_ack <= blk_req && !blk_ack;
    pv_data <= cur_mask[pv_addr[5:0]];
    fl_ack  <= 1'b0;
    if (fl_req && !fl_ack) begin
      if (ack_cnt == 2) begin
        fl_ack  <= 1'b1;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  always @(negedge CLK) begin
    if (fl_req && !fl_req_prev) begin
      cmd_q.push_back(fl_cmd);
      src_q.push_back(fl_src);
      dst_q.push_back(fl_dst);
    end
    if (map_upd) begin
      msrc_q.push_back(fl_src);
      mdst_q.push_back(fl_dst);
    end
    if (gc_done) done_cnt <= done_cnt + 1;
    fl_req_prev <= fl_req;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (gc_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cond_fl(input logic [27:0] src, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (fl_req && fl_src == src) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (state == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // After a full run, compare the new log entries to the model derived from the mask
  task automatic check_run(input string nm, input vec_t v, input int n0, input int m0, input int d0);
    int k;
    int ncmd;
    int nmap;
    ncmd = cmd_q.size() - n0;
    nmap = msrc_q.size() - m0;
    chk({nm, ".cmd_count"}, 64'(ncmd), 64'(v.exp_copies + 1));
    chk({nm, ".map_count"}, 64'(nmap), 64'(v.exp_copies));
    chk({nm, ".done_count"}, 64'(done_cnt - d0), 64'd1);
    k = 0;
    for (int p = 0; p < 64; p++) begin
      if (v.mask[p] && k < ncmd - 1 && k < nmap) begin
        chk({nm, ".copy_cmd"}, 64'(cmd_q[n0+k]), 64'd1);
        chk({nm, ".copy_src"}, 64'(src_q[n0+k]), 64'({v.vic, 6'(p)}));
        chk({nm, ".copy_dst"}, 64'(dst_q[n0+k]), 64'({v.dst, 6'(p)}));
        chk({nm, ".map_src"}, 64'(msrc_q[m0+k]), 64'({v.vic, 6'(p)}));
        chk({nm, ".map_dst"}, 64'(mdst_q[m0+k]), 64'({v.dst, 6'(p)}));
        k++;
      end
    end
    if (ncmd > 0) begin
      chk({nm, ".erase_cmd"}, 64'(cmd_q[n0+ncmd-1]), 64'd2);
      chk({nm, ".erase_src"}, 64'(src_q[n0+ncmd-1]), 64'(v.exp_erase));
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n0, m0, d0;
    bit ok;
    n0 = cmd_q.size();
    m0 = msrc_q.size();
    d0 = done_cnt;
    cur_vic = v.vic; cur_dst = v.dst; cur_mask = v.mask;
    gc_en = v.en; free_blk_cnt = v.cnt; gc_force = v.frc;
    @(negedge CLK);
    gc_force = 1'b0;
    wait_done(1000, ok);
    gc_en = 1'b0; free_blk_cnt = 11'd100;
    chk({nm, ".done_seen"}, 64'(ok), 64'd1);
    @(negedge CLK);
    chk({nm, ".done_pulse_len"}, 64'(gc_done), 64'd0);
    chk({nm, ".busy_after"}, 64'(gc_busy), 64'd0);
    chk({nm, ".state_after"}, 64'(state), 64'd0);
    check_run(nm, v, n0, m0, d0);
  endtask

  initial begin
    bit ok;
    vec_t v;
    vecs[0] = '{1'b1, 1'b0, 11'd15,  10'd5,    10'd9, 64'h0,                  0, 28'h140};
    vecs[1] = '{1'b1, 1'b0, 11'd15,  10'd5,    10'd9, 64'h8000_0000_0000_0081, 3, 28'h140};
    vecs[2] = '{1'b0, 1'b1, 11'd100, 10'd3,    10'd1, 64'h0000_0000_0000_0002, 1, 28'h0C0};
    vecs[3] = '{1'b1, 1'b0, 11'd0,   10'd1023, 10'd0, 64'h4000_0000_0000_0001, 2, 28'hFFC0};

    nRST = 1'b0; gc_en = 1'b0; gc_force = 1'b0; host_req = 1'b0; free_blk_cnt = 11'd100;
    repeat (3) @(negedge CLK);
    chk("reset.ctrl_outs", 64'({blk_req, pv_addr, fl_req, fl_cmd, map_upd, gc_busy, gc_done, state}), 64'd0);
    chk("reset.fl_addrs", 64'({fl_src, fl_dst}), 64'd0);
    nRST = 1'b1;

    // Count above threshold: no trigger
    gc_en = 1'b1; free_blk_cnt = 11'd17;
    repeat (5) @(negedge CLK);
    chk("above_thresh.state", 64'(state), 64'd0);
    chk("above_thresh.blk_req", 64'(blk_req), 64'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Host request during the page-7 copy
    cur_vic = 10'd5; cur_dst = 10'd9; cur_mask = 64'h8000_0000_0000_0081;
    gc_en = 1'b1; free_blk_cnt = 11'd15;
    wait_cond_fl(28'h147, 500, ok);
    chk("intr.reach_copy7", 64'(ok), 64'd1);
    gc_en = 1'b0; free_blk_cnt = 11'd100;
    host_req = 1'b1;
    chk("intr.copy7_dst", 64'(fl_dst), 64'h247);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (map_upd) begin ok = 1'b1; break; end
    end
    chk("intr.map_upd_seen", 64'(ok), 64'd1);
    chk("intr.map_src", 64'(fl_src), 64'h147);
    chk("intr.map_req_low", 64'(fl_req), 64'd0);
    @(negedge CLK);
    chk("intr.state", 64'(state), 64'd1);
    repeat (4) @(negedge CLK);
    chk("intr.held", 64'({gc_busy, state}), 64'h11);
    host_req = 1'b0;
    @(negedge CLK);
    chk("intr.resume_state", 64'(state), 64'd4);
    chk("intr.resume_pv_addr", 64'(pv_addr), 64'h148);
    wait_done(1000, ok);
    chk("intr.done_seen", 64'(ok), 64'd1);

    // Forced start held off by host traffic
    @(negedge CLK);
    cur_mask = 64'h0; cur_vic = 10'd2;
    host_req = 1'b1; gc_force = 1'b1;
    @(negedge CLK);
    gc_force = 1'b0;
    repeat (4) @(negedge CLK);
    chk("force_pend.idle", 64'(state), 64'd0);
    host_req = 1'b0;
    @(negedge CLK);
    chk("force_pend.ini", 64'(state), 64'd2);
    wait_done(1000, ok);
    chk("force_pend.done_seen", 64'(ok), 64'd1);

    // Asynchronous reset in the middle of a copy
    @(negedge CLK);
    cur_mask = 64'h1; cur_vic = 10'd5;
    gc_en = 1'b1; free_blk_cnt = 11'd15;
    wait_state(4'd7, 500, ok);
    chk("rst_mid.reach_wait", 64'(ok), 64'd1);
    free_blk_cnt = 11'd100;
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid.ctrl_outs", 64'({blk_req, pv_addr, fl_req, fl_cmd, map_upd, gc_busy, gc_done, state}), 64'd0);
    chk("rst_mid.fl_addrs", 64'({fl_src, fl_dst}), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (10) @(negedge CLK);
    chk("rst_mid.stays_idle", 64'({gc_busy, state}), 64'd0);

    // Back-to-back runs with the count stuck below threshold
    cur_mask = 64'h0; free_blk_cnt = 11'd3;
    wait_done(1000, ok);
    chk("b2b.first_done", 64'(ok), 64'd1);
    @(negedge CLK);
    chk("b2b.idle_gap", 64'(state), 64'd0);
    @(negedge CLK);
    chk("b2b.second_ini", 64'(state), 64'd2);
    free_blk_cnt = 11'd100; gc_en = 1'b0;
    wait_done(1000, ok);
    chk("b2b.second_done", 64'(ok), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
